// File: rtl/serializer_arbiter.sv
// serializer_arbiter
// Round-robin arbiter sharing one 16-bit serializer among N_CH requesters.
// A word plus its bit count is accepted from the winning channel over a
// val/ready handshake, words with an illegal count are discarded, and legal
// words are handed to the serializer one at a time. The arbiter then waits
// for the serializer's busy period to end before granting again.
//
// Ports:
//   clk_i          clock
//   arst_i         asynchronous active-high reset
//   req_data_i     per-channel word, channel k at [16k+15:16k]
//   req_mod_i      per-channel bit count (0 = 16 bits, 3..15 valid, 1/2 illegal)
//   req_val_i      per-channel word valid
//   req_ready_o    one-hot accept strobe (combinational, IDLE only)
//   ser_data_o     word to serializer
//   ser_data_mod_o bit count to serializer
//   ser_data_val_o issue strobe to serializer
//   ser_busy_i     serializer busy
//   grant_id_o     channel of the word in flight
//   active_o       a word is in flight
//   drop_o         pulse: illegal-count word accepted and discarded
//   timeout_o      pulse: serializer never raised busy after an issue
//   issued_cnt_o   words issued since reset (wraps)
//
// state       | meaning
// S_IDLE      | arbitrate; accept one word when the serializer is not busy
// S_ISSUE     | one-cycle issue strobe to the serializer
// S_WAIT_BUSY | waiting for busy to rise, bounded by BUSY_TIMEOUT
// S_WAIT_DONE | serializer busy; wait for it to fall

module serializer_arbiter #(
    parameter int N_CH         = 4,
    parameter int BUSY_TIMEOUT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [N_CH*16-1:0]      req_data_i,
    input  logic [N_CH*4-1:0]       req_mod_i,
    input  logic [N_CH-1:0]         req_val_i,
    output logic [N_CH-1:0]         req_ready_o,
    output logic [15:0]             ser_data_o,
    output logic [3:0]              ser_data_mod_o,
    output logic                    ser_data_val_o,
    input  logic                    ser_busy_i,
    output logic [$clog2(N_CH)-1:0] grant_id_o,
    output logic                    active_o,
    output logic                    drop_o,
    output logic                    timeout_o,
    output logic [CNT_W-1:0]        issued_cnt_o
);

    localparam int ID_W  = $clog2(N_CH);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ID_W:0] N_CH_L = (ID_W + 1)'(N_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [15:0]       data_q, data_d;
    logic [3:0]        mod_q, mod_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              timeout_q, timeout_d;

    logic [N_CH-1:0]   req_rot;
    logic [ID_W-1:0]   gnt_off;
    logic [ID_W:0]     gnt_sum;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic [15:0]       gnt_data;
    logic [3:0]        gnt_mod;
    logic              grant;

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
        if (id == ID_W'(N_CH - 1)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // Rotate the request vector so bit 0 is the channel at rr_ptr; the first
    // set bit is then the winner's offset from the pointer.
    always_comb begin
        req_rot = N_CH'({req_val_i, req_val_i} >> rr_ptr_q);
        gnt_any = 1'b0;
        gnt_off = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!gnt_any && req_rot[i]) begin
                gnt_any = 1'b1;
                gnt_off = ID_W'(i);
            end
        end
        gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
        if (gnt_sum >= N_CH_L) begin
            gnt_sum = gnt_sum - N_CH_L;
        end
        gnt_id   = gnt_sum[ID_W-1:0];
        gnt_data = '0;
        gnt_mod  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_id == ID_W'(i)) begin
                gnt_data = req_data_i[16*i +: 16];
                gnt_mod  = req_mod_i[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gid_d     = gid_q;
        data_d    = data_q;
        mod_d     = mod_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        drop_d    = 1'b0;
        timeout_d = 1'b0;
        grant     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_any && !ser_busy_i) begin
                    grant  = 1'b1;
                    gid_d  = gnt_id;
                    data_d = gnt_data;
                    mod_d  = gnt_mod;
                    if (gnt_mod == 4'd1 || gnt_mod == 4'd2) begin
                        drop_d   = 1'b1;
                        rr_ptr_d = ptr_after(gnt_id);
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (ser_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_W'(BUSY_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        rr_ptr_d  = ptr_after(gid_q);
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!ser_busy_i) begin
                    rr_ptr_d = ptr_after(gid_q);
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gid_q     <= '0;
            data_q    <= '0;
            mod_q     <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gid_q     <= gid_d;
            data_q    <= data_d;
            mod_q     <= mod_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held,
    // even though the registered state already sits in IDLE.
    assign req_ready_o    = (grant && !arst_i) ? (N_CH'(1) << gnt_id) : '0;
    assign ser_data_o     = data_q;
    assign ser_data_mod_o = mod_q;
    assign ser_data_val_o = (state_q == S_ISSUE);
    assign grant_id_o     = gid_q;
    assign active_o       = (state_q != S_IDLE);
    assign drop_o         = drop_q;
    assign timeout_o      = timeout_q;
    assign issued_cnt_o   = cnt_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
module tb_serializer_arbiter;

    localparam int N_CH = 4;
    localparam int BT   = 4;

    logic                 clk_i;
    logic                 arst_i;
    logic [N_CH*16-1:0]   req_data_i;
    logic [N_CH*4-1:0]    req_mod_i;
    logic [N_CH-1:0]      req_val_i;
    logic [N_CH-1:0]      req_ready_o;
    logic [15:0]          ser_data_o;
    logic [3:0]           ser_data_mod_o;
    logic                 ser_data_val_o;
    logic                 ser_busy_i;
    logic [1:0]           grant_id_o;
    logic                 active_o;
    logic                 drop_o;
    logic                 timeout_o;
    logic [15:0]          issued_cnt_o;

    logic [N_CH-1:0]      w_ready;
    logic [15:0]          w_data;
    logic [3:0]           w_mod;
    logic                 w_val;
    logic [1:0]           w_gid;
    logic                 w_active;
    logic                 w_drop;
    logic                 w_tmo;
    logic [1:0]           w_cnt;

    serializer_arbiter #(.N_CH(N_CH), .BUSY_TIMEOUT(BT), .CNT_W(16)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .req_data_i(req_data_i), .req_mod_i(req_mod_i), .req_val_i(req_val_i),
        .req_ready_o(req_ready_o),
        .ser_data_o(ser_data_o), .ser_data_mod_o(ser_data_mod_o),
        .ser_data_val_o(ser_data_val_o), .ser_busy_i(ser_busy_i),
        .grant_id_o(grant_id_o), .active_o(active_o), .drop_o(drop_o),
        .timeout_o(timeout_o), .issued_cnt_o(issued_cnt_o)
    );

    // Narrow-counter copy on the same inputs: exercises counter wrap quickly.
    serializer_arbiter #(.N_CH(N_CH), .BUSY_TIMEOUT(BT), .CNT_W(2)) dut_w (
        .clk_i(clk_i), .arst_i(arst_i),
        .req_data_i(req_data_i), .req_mod_i(req_mod_i), .req_val_i(req_val_i),
        .req_ready_o(w_ready),
        .ser_data_o(w_data), .ser_data_mod_o(w_mod),
        .ser_data_val_o(w_val), .ser_busy_i(ser_busy_i),
        .grant_id_o(w_gid), .active_o(w_active), .drop_o(w_drop),
        .timeout_o(w_tmo), .issued_cnt_o(w_cnt)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Stimulus control
    logic [23:0]     pend[$];          // {ch[3:0], data[15:0], mod[3:0]}
    logic [N_CH-1:0] hs_seen;
    logic            saw_val;
    bit              rand_en  = 1'b0;
    bit              force_hi = 1'b0;
    int              ser_mode = 0;     // 0: busy 1 cycle after val, 1: never busy
    int              ser_len  = 16;

    // Observation logs
    int lg_ready[$], lg_iss_data[$], lg_iss_mod[$], lg_iss_gid[$], lg_iss_cyc[$];
    int lg_drop_cyc[$], lg_tmo_cyc[$];
    int busy_fall_cyc, active_fall_cyc;
    bit prev_busy, prev_active;

    task automatic clear_logs();
        lg_ready.delete(); lg_iss_data.delete(); lg_iss_mod.delete();
        lg_iss_gid.delete(); lg_iss_cyc.delete(); lg_drop_cyc.delete(); lg_tmo_cyc.delete();
        busy_fall_cyc = -1; active_fall_cyc = -1;
    endtask

    task automatic push_word(input int ch, input logic [15:0] data, input logic [3:0] mod);
        pend.push_back({4'(ch), data, mod});
    endtask

    // Requester and serializer models: change inputs 1 time unit after posedge.
    initial begin
        logic [N_CH-1:0] cur_val;
        logic [15:0]     cur_data [N_CH];
        logic [3:0]      cur_mod  [N_CH];
        logic            got;
        logic [23:0]     ent;
        int              ser_rem;
        cur_val = '0;
        for (int k = 0; k < N_CH; k++) begin cur_data[k] = '0; cur_mod[k] = '0; end
        ser_rem = 0;
        req_val_i = '0; req_data_i = '0; req_mod_i = '0; ser_busy_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N_CH; k++) begin
                if (hs_seen[k]) cur_val[k] = 1'b0;
                if (!cur_val[k]) begin
                    got = 1'b0;
                    ent = '0;
                    for (int j = 0; j < pend.size(); j++) begin
                        if (!got && pend[j][23:20] == 4'(k)) begin
                            ent = pend[j];
                            pend.delete(j);
                            got = 1'b1;
                        end
                    end
                    if (got) begin
                        cur_val[k] = 1'b1; cur_data[k] = ent[19:4]; cur_mod[k] = ent[3:0];
                    end else if (rand_en && $urandom_range(0, 3) == 0) begin
                        cur_val[k]  = 1'b1;
                        cur_data[k] = 16'($urandom);
                        cur_mod[k]  = 4'($urandom_range(0, 15));
                    end
                end
                req_data_i[16*k +: 16] = cur_data[k];
                req_mod_i[4*k +: 4]    = cur_mod[k];
            end
            req_val_i = cur_val;
            if (saw_val) begin
                if (rand_en) ser_rem = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
                else         ser_rem = (ser_mode == 0) ? ser_len : 0;
            end else if (ser_rem > 0) begin
                ser_rem--;
            end
            ser_busy_i = (ser_rem > 0) || force_hi;
        end
    end

    // Behavioural reference and compare process: runs on every falling edge.
    initial begin
        bit              m_flight, m_gotbusy, m_drop, m_tmo, nd, nt;
        int              m_age, m_ptr, m_gid, m_data, m_mod, win, c;
        int unsigned     m_cnt;
        logic [N_CH-1:0] exp_ready;
        m_flight = 0; m_gotbusy = 0; m_drop = 0; m_tmo = 0;
        m_age = 0; m_ptr = 0; m_gid = 0; m_data = 0; m_mod = 0; m_cnt = 0;
        hs_seen = '0; saw_val = 1'b0;
        prev_busy = 0; prev_active = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (arst_i) begin
                m_flight = 0; m_gotbusy = 0; m_drop = 0; m_tmo = 0;
                m_age = 0; m_ptr = 0; m_gid = 0; m_data = 0; m_mod = 0; m_cnt = 0;
            end
            win = -1;
            if (!arst_i && !m_flight && !ser_busy_i) begin
                for (int i = 0; i < N_CH; i++) begin
                    c = (m_ptr + i) % N_CH;
                    if (win < 0 && req_val_i[c]) win = c;
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;

            check("ready",      32'(req_ready_o),    32'(exp_ready));
            check("ser_data",   32'(ser_data_o),     m_data);
            check("ser_mod",    32'(ser_data_mod_o), m_mod);
            check("ser_val",    32'(ser_data_val_o), 32'(m_flight && m_age == 0));
            check("grant_id",   32'(grant_id_o),     m_gid);
            check("active",     32'(active_o),       32'(m_flight));
            check("drop",       32'(drop_o),         32'(m_drop));
            check("timeout",    32'(timeout_o),      32'(m_tmo));
            check("issued_cnt", 32'(issued_cnt_o),   m_cnt % 65536);
            check("issued_w2",  32'(w_cnt),          m_cnt % 4);

            // logs of what the DUT actually did, for directed scenario checks
            if (req_ready_o != '0) lg_ready.push_back(int'(req_ready_o));
            if (ser_data_val_o) begin
                lg_iss_data.push_back(int'(ser_data_o)); lg_iss_mod.push_back(int'(ser_data_mod_o));
                lg_iss_gid.push_back(int'(grant_id_o));  lg_iss_cyc.push_back(cyc);
            end
            if (drop_o)    lg_drop_cyc.push_back(cyc);
            if (timeout_o) lg_tmo_cyc.push_back(cyc);
            if (prev_busy && !ser_busy_i) busy_fall_cyc = cyc;
            if (prev_active && !active_o) active_fall_cyc = cyc;
            prev_busy = ser_busy_i; prev_active = active_o;
            hs_seen = req_ready_o & req_val_i;
            saw_val = ser_data_val_o;

            // advance the model by one clock
            if (!arst_i) begin
                nd = 0; nt = 0;
                if (!m_flight) begin
                    if (win >= 0) begin
                        m_gid = win;
                        m_data = int'(req_data_i[16*win +: 16]);
                        m_mod  = int'(req_mod_i[4*win +: 4]);
                        if (m_mod == 1 || m_mod == 2) begin
                            nd = 1; m_ptr = (win + 1) % N_CH;
                        end else begin
                            m_flight = 1; m_age = 0; m_gotbusy = 0;
                        end
                    end
                end else if (m_age == 0) begin
                    m_age = 1; m_cnt++;
                end else if (!m_gotbusy) begin
                    if (ser_busy_i) m_gotbusy = 1;
                    else if (m_age == BT) begin
                        nt = 1; m_flight = 0; m_ptr = (m_gid + 1) % N_CH;
                    end else m_age++;
                end else if (!ser_busy_i) begin
                    m_flight = 0; m_ptr = (m_gid + 1) % N_CH;
                end
                m_drop = nd; m_tmo = nt;
            end
        end
    end

    task automatic wait_iss(input int n, input int budget);
        int k = 0;
        while (lg_iss_gid.size() < n && k < budget) begin @(negedge clk_i); k++; end
        if (lg_iss_gid.size() < n) check("wait_issue_budget", lg_iss_gid.size(), n);
    endtask

    task automatic wait_drop(input int n, input int budget);
        int k = 0;
        while (lg_drop_cyc.size() < n && k < budget) begin @(negedge clk_i); k++; end
        if (lg_drop_cyc.size() < n) check("wait_drop_budget", lg_drop_cyc.size(), n);
    endtask

    task automatic wait_tmo(input int n, input int budget);
        int k = 0;
        while (lg_tmo_cyc.size() < n && k < budget) begin @(negedge clk_i); k++; end
        if (lg_tmo_cyc.size() < n) check("wait_timeout_budget", lg_tmo_cyc.size(), n);
    endtask

    task automatic wait_quiet(input int budget);
        int k = 0;
        while (!(pend.size() == 0 && req_val_i == '0 && !active_o && !ser_busy_i) && k < budget) begin
            @(negedge clk_i); k++;
        end
        if (k >= budget) check("wait_quiet_budget", 32'(active_o), 0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2 arst_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i);
        #1 arst_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_i = 1'b1;
        clear_logs();
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_cnt",    32'(issued_cnt_o), 0);
        check("rst_active", 32'(active_o), 0);
        @(posedge clk_i);
        #1 arst_i = 1'b0;

        // single channel
        clear_logs();
        ser_mode = 0; ser_len = 16;
        push_word(2, 16'hA5C3, 4'd0);
        wait_iss(1, 50);
        wait_quiet(100);
        check("t2_ready_count", lg_ready.size(), 1);
        check("t2_ready_vec",   qat(lg_ready, 0), 32'h4);
        check("t2_issue_count", lg_iss_gid.size(), 1);
        check("t2_data",        qat(lg_iss_data, 0), 32'hA5C3);
        check("t2_mod",         qat(lg_iss_mod, 0), 0);
        check("t2_gid",         qat(lg_iss_gid, 0), 2);
        check("t2_issued",      32'(issued_cnt_o), 1);
        check("t2_active_lag",  active_fall_cyc - busy_fall_cyc, 1);

        // all channels requesting
        do_reset();
        clear_logs();
        push_word(0, 16'h1111, 4'd0); push_word(1, 16'h2222, 4'd0);
        push_word(2, 16'h3333, 4'd0); push_word(3, 16'h4444, 4'd0);
        push_word(0, 16'h1112, 4'd0);
        wait_iss(5, 300);
        wait_quiet(100);
        check("t3_gid0", qat(lg_iss_gid, 0), 0);
        check("t3_gid1", qat(lg_iss_gid, 1), 1);
        check("t3_gid2", qat(lg_iss_gid, 2), 2);
        check("t3_gid3", qat(lg_iss_gid, 3), 3);
        check("t3_gid4", qat(lg_iss_gid, 4), 0);
        check("t3_data3", qat(lg_iss_data, 3), 32'h4444);
        check("t3_data4", qat(lg_iss_data, 4), 32'h1112);

        // illegal mods
        clear_logs();
        push_word(1, 16'h1234, 4'd1);
        wait_drop(1, 30);
        push_word(1, 16'h5678, 4'd2);
        wait_drop(2, 30);
        repeat (3) @(negedge clk_i);
        check("t4_drops",    lg_drop_cyc.size(), 2);
        check("t4_no_issue", lg_iss_gid.size(), 0);
        check("t4_ready0",   qat(lg_ready, 0), 32'h2);
        check("t4_ready1",   qat(lg_ready, 1), 32'h2);
        push_word(0, 16'h0ABC, 4'd8); push_word(2, 16'h2BCD, 4'd5);
        wait_iss(2, 200);
        wait_quiet(100);
        check("t4_next_gid",  qat(lg_iss_gid, 0), 2);
        check("t4_next_data", qat(lg_iss_data, 0), 32'h2BCD);
        check("t4_next_mod",  qat(lg_iss_mod, 0), 5);
        check("t4_then_gid",  qat(lg_iss_gid, 1), 0);

        // serializer never busy
        clear_logs();
        ser_mode = 1;
        push_word(3, 16'h3C3C, 4'd7); push_word(0, 16'h0F0F, 4'd12);
        wait_iss(2, 100);
        wait_tmo(2, 100);
        wait_quiet(50);
        ser_mode = 0;
        check("t5_tmo_delay", qat(lg_tmo_cyc, 0) - qat(lg_iss_cyc, 0), BT + 1);
        check("t5_first_gid", qat(lg_iss_gid, 0), 3);
        check("t5_next_gid",  qat(lg_iss_gid, 1), 0);
        check("t5_tmo_count", lg_tmo_cyc.size(), 2);

        // reset during WAIT_DONE
        clear_logs();
        push_word(2, 16'h5A5A, 4'd0);
        wait_iss(1, 50);
        repeat (4) @(negedge clk_i);
        #2 arst_i = 1'b1;
        #1;
        check("t6_rst_ready",  32'(req_ready_o), 0);
        check("t6_rst_data",   32'(ser_data_o), 0);
        check("t6_rst_mod",    32'(ser_data_mod_o), 0);
        check("t6_rst_val",    32'(ser_data_val_o), 0);
        check("t6_rst_gid",    32'(grant_id_o), 0);
        check("t6_rst_active", 32'(active_o), 0);
        check("t6_rst_cnt",    32'(issued_cnt_o), 0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 arst_i = 1'b0;
        clear_logs();
        push_word(0, 16'h0001, 4'd3); push_word(3, 16'h0003, 4'd15);
        wait_iss(2, 200);
        check("t6_first_gid", qat(lg_iss_gid, 0), 0);
        check("t6_next_gid",  qat(lg_iss_gid, 1), 3);
        push_word(1, 16'hBEEF, 4'd9); push_word(2, 16'hCAFE, 4'd4);
        wait_iss(4, 200);
        wait_quiet(100);
        check("t7_cnt16", 32'(issued_cnt_o), 4);
        check("t7_cnt2_wrapped", 32'(w_cnt), 0);

        // busy held high while idle blocks grants
        force_hi = 1'b1;
        repeat (2) @(negedge clk_i);
        clear_logs();
        push_word(1, 16'h7777, 4'd0);
        repeat (10) @(negedge clk_i);
        check("t7_busy_block", lg_ready.size(), 0);
        force_hi = 1'b0;
        wait_iss(1, 40);
        check("t7_after_busy_gid", qat(lg_iss_gid, 0), 1);
        wait_quiet(100);

        // randomized traffic against the reference model
        rand_en = 1'b1;
        repeat (3000) @(negedge clk_i);
        rand_en = 1'b0;
        wait_quiet(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
